// File: rtl/monty_pkg.sv
// Shared definitions for the iterative word-reduction Montgomery datapath.
//   state_e  : controller states
//   clog2    : ceiling log2 for elaboration-time widths
//   build_q  : assembles q = qH*2^(R+Y) + 1 (result is QMAXW bits wide;
//              callers cast it down to their own width)
package monty_pkg;

  localparam int unsigned QMAXW = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_ACC,
    ST_SUB,
    ST_DONE
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic logic [QMAXW-1:0] build_q(input logic [QMAXW-1:0] qh,
                                               input int unsigned        r,
                                               input int unsigned        y);
    return (qh << (r + y)) | QMAXW'(1);
  endfunction

endpackage

// File: rtl/monty_wordred_step.sv
// One word-reduction step's arithmetic: m = (-a_lo) mod 2^R, the carry that
// the discarded low word contributes, and a MUL_LAT-stage registered m*qH.
//   clk  in  clock
//   a_lo in  low R bits of the accumulator (held stable for the whole step)
//   qh   in  modulus high part
//   cy   out 1 when a_lo != 0 (combinational)
//   prod out m*qH, valid MUL_LAT cycles after a_lo/qh settle
module monty_wordred_step #(
  parameter int unsigned R       = 34,
  parameter int unsigned QH_LEN  = 26,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic                   clk,
  input  logic [R-1:0]           a_lo,
  input  logic [QH_LEN-1:0]      qh,
  output logic                   cy,
  output logic [QH_LEN+R-1:0]    prod
);

  localparam int unsigned PW = QH_LEN + R;

  logic [R-1:0]  m;
  logic [PW-1:0] mq;
  logic [PW-1:0] pipe_q [MUL_LAT];

  // Low word of A + m*q is zero when a_lo is zero, else exactly 2^R,
  // so the shifted-out part contributes a single carry.
  assign m  = -a_lo;
  assign cy = |a_lo;
  assign mq = PW'(m) * PW'(qh);

  // No reset: the operands are held for MUL_LAT cycles before the output
  // is consumed, so stale contents are always flushed first.
  always_ff @(posedge clk) begin
    pipe_q[0] <= mq;
    for (int unsigned i = 1; i < MUL_LAT; i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign prod = pipe_q[MUL_LAT-1];

endmodule

// File: rtl/iterative_wordred.sv
// Multi-word Montgomery reduction for q = qH*2^(R+Y)+1. Applies 1..N_MAX
// word-reduction steps A <- (A + m*q)/2^R on one shared pipelined multiplier,
// optionally followed by a conditional subtraction of q.
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (ready only when idle)
//   C, qH, steps        operand, modulus high part, step count (latched at accept)
//   out_valid/out_ready result handshake
//   T                   result (Q_LEN+1 bits)
//   busy                high whenever not idle
module iterative_wordred
  import monty_pkg::*;
#(
  parameter  int unsigned Q_LEN     = 60,
  parameter  int unsigned R         = 34,
  parameter  int unsigned Y         = 0,
  parameter  int unsigned N_MAX     = 2,
  parameter  int unsigned MUL_LAT   = 2,
  parameter  int unsigned FINAL_SUB = 1,
  localparam int unsigned QH_LEN    = Q_LEN - R - Y,
  localparam int unsigned K         = Q_LEN + R * N_MAX,
  localparam int unsigned SW        = clog2(N_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      C,
  input  logic [QH_LEN-1:0] qH,
  input  logic [SW-1:0]     steps,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [Q_LEN:0]    T,
  output logic              busy
);

  localparam int unsigned MW = clog2(MUL_LAT + 1);

  state_e              state_q, state_d;
  logic [K-1:0]        a_q, a_d;
  logic [QH_LEN-1:0]   qh_q, qh_d;
  logic [SW-1:0]       cnt_q, cnt_d;
  logic [MW-1:0]       mcnt_q, mcnt_d;
  logic [Q_LEN:0]      t_q, t_d;

  logic [SW-1:0]       steps_eff;
  logic                cy;
  logic [QH_LEN+R-1:0] prod;
  logic [K-1:0]        a_next;
  logic [Q_LEN:0]      q_w;
  logic [K-1:0]        q_k;
  logic [K-1:0]        a_sub;

  monty_wordred_step #(
    .R       (R),
    .QH_LEN  (QH_LEN),
    .MUL_LAT (MUL_LAT)
  ) u_step (
    .clk  (clk),
    .a_lo (a_q[R-1:0]),
    .qh   (qh_q),
    .cy   (cy),
    .prod (prod)
  );

  assign q_w    = (Q_LEN+1)'(build_q(QMAXW'(qh_q), R, Y));
  assign q_k    = K'(q_w);
  assign a_sub  = a_q - q_k;
  assign a_next = (a_q >> R) + (K'(prod) << Y) + K'(cy);

  always_comb begin
    if (steps == '0) begin
      steps_eff = SW'(1);
    end else if (steps > SW'(N_MAX)) begin
      steps_eff = SW'(N_MAX);
    end else begin
      steps_eff = steps;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qh_d    = qh_q;
    cnt_d   = cnt_q;
    mcnt_d  = mcnt_q;
    t_d     = t_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = C;
          qh_d    = qH;
          cnt_d   = steps_eff;
          mcnt_d  = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        if (mcnt_q == MW'(MUL_LAT - 1)) begin
          state_d = ST_ACC;
        end else begin
          mcnt_d = mcnt_q + MW'(1);
        end
      end
      ST_ACC: begin
        a_d    = a_next;
        mcnt_d = '0;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          if (FINAL_SUB != 0) begin
            state_d = ST_SUB;
          end else begin
            t_d     = (Q_LEN+1)'(a_next);
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_MUL;
        end
      end
      ST_SUB: begin
        t_d     = (Q_LEN+1)'((a_q >= q_k) ? a_sub : a_q);
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      qh_q    <= '0;
      cnt_q   <= '0;
      mcnt_q  <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qh_q    <= qh_d;
      cnt_q   <= cnt_d;
      mcnt_q  <= mcnt_d;
      t_q     <= t_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign T         = t_q;

endmodule
